// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads the PC, fetches one word over req/ack,
// hands it to decode over valid/ready and steers the PC (advance or branch).
module fetch_unit #(
   parameter int ADDR_W   = 16,
   parameter int INSTR_W  = 16,
   parameter int MAX_WAIT = 255
) (
   input  logic               I_clk,
   input  logic               I_reset,
   input  logic [ADDR_W-1:0]  I_pc,
   output logic               O_pc_enable,
   output logic               O_pc_write,
   output logic [ADDR_W-1:0]  O_pc_target,
   output logic               O_mem_req,
   output logic [ADDR_W-1:0]  O_mem_addr,
   input  logic               I_mem_ack,
   input  logic [INSTR_W-1:0] I_mem_data,
   output logic [INSTR_W-1:0] O_instr,
   output logic               O_instr_valid,
   input  logic               I_instr_ready,
   input  logic               I_branch,
   input  logic [ADDR_W-1:0]  I_branch_target,
   output logic               O_fetch_err
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  L_MAX   = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0]  L_LAST  = CNT_W'(MAX_WAIT - 1);
   localparam logic [ADDR_W-1:0] L_ALIGN = ~ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_ADV,
      S_HOLD
   } state_t;

   state_t               r_state;
   logic                 r_pend;
   logic [ADDR_W-1:0]    r_tgt;
   logic [CNT_W-1:0]     r_wait_cnt;
   logic [INSTR_W-1:0]   r_instr;
   logic                 r_valid;
   logic                 r_err;
   logic                 r_pc_en;
   logic                 r_pc_wr;
   logic                 r_mem_req;
   logic                 w_redirect;

   // A redirect is honoured in every state except the post-reset idle cycle.
   assign w_redirect = I_branch && (r_state != S_IDLE);

   assign O_pc_enable   = r_pc_en;
   assign O_pc_write    = r_pc_wr;
   assign O_pc_target   = r_tgt;
   assign O_mem_req     = r_mem_req;
   assign O_mem_addr    = r_mem_req ? (I_pc & L_ALIGN) : '0;
   assign O_instr       = r_instr;
   assign O_instr_valid = r_valid;
   assign O_fetch_err   = r_err;

   // Fetch FSM; every output is registered alongside the state transition.
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         r_state    <= S_IDLE;
         r_pend     <= 1'b0;
         r_tgt      <= '0;
         r_wait_cnt <= '0;
         r_instr    <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_pc_en    <= 1'b0;
         r_pc_wr    <= 1'b0;
         r_mem_req  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_state   <= S_REQ;
               r_mem_req <= 1'b1;
            end
            S_REQ: begin
               if (I_mem_ack) begin
                  r_wait_cnt <= '0;
                  r_mem_req  <= 1'b0;
                  r_state    <= S_ADV;
                  r_pc_en    <= 1'b1;
                  r_pc_wr    <= r_pend || I_branch;
                  if (!r_pend && !I_branch) begin
                     r_instr <= I_mem_data;
                     r_valid <= 1'b1;
                  end
               end else begin
                  if (r_wait_cnt != L_MAX)
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  if (r_wait_cnt >= L_LAST)
                     r_err <= 1'b1;
               end
            end
            S_ADV: begin
               if (I_branch) begin
                  r_pc_en <= 1'b1;
                  r_pc_wr <= 1'b1;
               end else begin
                  r_pend  <= 1'b0;
                  r_pc_en <= 1'b0;
                  r_pc_wr <= 1'b0;
                  if (r_valid) begin
                     r_state <= S_HOLD;
                  end else begin
                     r_state   <= S_REQ;
                     r_mem_req <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (I_branch) begin
                  r_state <= S_ADV;
                  r_pc_en <= 1'b1;
                  r_pc_wr <= 1'b1;
               end else if (I_instr_ready) begin
                  r_valid   <= 1'b0;
                  r_state   <= S_REQ;
                  r_mem_req <= 1'b1;
               end
            end
         endcase
         if (w_redirect) begin
            r_tgt   <= I_branch_target;
            r_pend  <= 1'b1;
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

   logic        I_clk = 1'b0;
   logic        I_reset;
   logic [15:0] I_pc;
   logic        O_pc_enable;
   logic        O_pc_write;
   logic [15:0] O_pc_target;
   logic        O_mem_req;
   logic [15:0] O_mem_addr;
   logic        I_mem_ack;
   logic [15:0] I_mem_data;
   logic [15:0] O_instr;
   logic        O_instr_valid;
   logic        I_instr_ready;
   logic        I_branch;
   logic [15:0] I_branch_target;
   logic        O_fetch_err;

   int total = 0;
   int bad   = 0;

   logic [15:0] pc_q;

   fetch_unit dut (
      .I_clk           (I_clk),
      .I_reset         (I_reset),
      .I_pc            (I_pc),
      .O_pc_enable     (O_pc_enable),
      .O_pc_write      (O_pc_write),
      .O_pc_target     (O_pc_target),
      .O_mem_req       (O_mem_req),
      .O_mem_addr      (O_mem_addr),
      .I_mem_ack       (I_mem_ack),
      .I_mem_data      (I_mem_data),
      .O_instr         (O_instr),
      .O_instr_valid   (O_instr_valid),
      .I_instr_ready   (I_instr_ready),
      .I_branch        (I_branch),
      .I_branch_target (I_branch_target),
      .O_fetch_err     (O_fetch_err)
   );

   always #5 I_clk = ~I_clk;

   // Stand-in for the pc unit.
   always @(posedge I_clk) begin
      if (I_reset)
         pc_q <= 16'h0000;
      else if (O_pc_enable)
         pc_q <= O_pc_write ? O_pc_target : pc_q + 16'd2;
   end
   assign I_pc = pc_q;

   function automatic logic [15:0] memf(input logic [15:0] a);
      return (a * 16'd7) ^ 16'hC35A;
   endfunction

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   logic [15:0] last_addr, exp_addr, br_tgt, exp_instr, tgt;
   bit          br_pend, exp_valid, busy, prev_req, br, rdy, ack;
   int          lat, age;

   initial begin
      I_reset = 1'b1;
      I_mem_ack = 1'b0;
      I_mem_data = 16'h0000;
      I_instr_ready = 1'b0;
      I_branch = 1'b0;
      I_branch_target = 16'h0000;
      tick();
      tick();
      chk1("rst_valid", O_instr_valid, 1'b0);
      chk1("rst_err", O_fetch_err, 1'b0);
      chk1("rst_req", O_mem_req, 1'b0);
      chk1("rst_pc_en", O_pc_enable, 1'b0);
      chk1("rst_pc_wr", O_pc_write, 1'b0);
      chk16("rst_instr", O_instr, 16'h0000);

      // First fetch, ack two cycles after request
      I_reset = 1'b0;
      tick();
      chk1("f0_req", O_mem_req, 1'b1);
      chk16("f0_addr", O_mem_addr, 16'h0000);
      tick();
      tick();
      I_mem_ack = 1'b1;
      I_mem_data = 16'hA001;
      tick();
      I_mem_ack = 1'b0;
      chk1("f0_valid", O_instr_valid, 1'b1);
      chk16("f0_instr", O_instr, 16'hA001);
      chk1("f0_pc_en", O_pc_enable, 1'b1);
      chk1("f0_pc_wr", O_pc_write, 1'b0);
      chk1("f0_req_low", O_mem_req, 1'b0);
      tick();
      chk1("f0_pc_en_once", O_pc_enable, 1'b0);
      chk16("f0_pc_adv", pc_q, 16'h0002);

      // Decode stalls
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("hold_valid", O_instr_valid, 1'b1);
         chk16("hold_instr", O_instr, 16'hA001);
         chk1("hold_no_req", O_mem_req, 1'b0);
      end
      I_instr_ready = 1'b1;
      tick();
      I_instr_ready = 1'b0;
      chk1("f1_req", O_mem_req, 1'b1);
      chk16("f1_addr", O_mem_addr, 16'h0002);
      chk1("f1_valid_drop", O_instr_valid, 1'b0);

      // Zero-wait ack
      I_mem_ack = 1'b1;
      I_mem_data = 16'h1234;
      tick();
      I_mem_ack = 1'b0;
      chk1("f1_valid", O_instr_valid, 1'b1);
      chk16("f1_instr", O_instr, 16'h1234);
      chk1("f1_pc_en", O_pc_enable, 1'b1);
      tick();

      // Branch in HOLD together with ready: branch wins
      I_branch = 1'b1;
      I_branch_target = 16'h0100;
      I_instr_ready = 1'b1;
      tick();
      I_branch = 1'b0;
      I_instr_ready = 1'b0;
      chk1("bh_valid", O_instr_valid, 1'b0);
      chk1("bh_pc_en", O_pc_enable, 1'b1);
      chk1("bh_pc_wr", O_pc_write, 1'b1);
      chk16("bh_tgt", O_pc_target, 16'h0100);
      chk1("bh_no_req", O_mem_req, 1'b0);
      tick();
      chk1("bh_req", O_mem_req, 1'b1);
      chk16("bh_addr", O_mem_addr, 16'h0100);

      // Branch in REQ: request held, returned data discarded
      I_branch = 1'b1;
      I_branch_target = 16'h0300;
      tick();
      I_branch = 1'b0;
      chk1("br_req_kept", O_mem_req, 1'b1);
      chk16("br_addr_kept", O_mem_addr, 16'h0100);
      tick();
      tick();
      I_mem_ack = 1'b1;
      I_mem_data = 16'hDEAD;
      tick();
      I_mem_ack = 1'b0;
      chk1("br_discard", O_instr_valid, 1'b0);
      chk1("br_pc_en", O_pc_enable, 1'b1);
      chk1("br_pc_wr", O_pc_write, 1'b1);
      chk16("br_tgt", O_pc_target, 16'h0300);
      tick();
      chk1("br_req", O_mem_req, 1'b1);
      chk16("br_addr", O_mem_addr, 16'h0300);
      chk1("br_still_no_valid", O_instr_valid, 1'b0);

      // Memory timeout
      for (int i = 0; i < 252; i++) tick();
      chk1("to_not_yet", O_fetch_err, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk1("to_err", O_fetch_err, 1'b1);
      chk1("to_req_held", O_mem_req, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk1("to_sticky", O_fetch_err, 1'b1);

      // Reset while requesting; late ack in IDLE ignored
      I_reset = 1'b1;
      tick();
      I_reset = 1'b0;
      I_mem_ack = 1'b1;
      I_mem_data = 16'hBEEF;
      chk1("mr_req", O_mem_req, 1'b0);
      chk1("mr_err", O_fetch_err, 1'b0);
      chk1("mr_valid", O_instr_valid, 1'b0);
      chk1("mr_pc_en", O_pc_enable, 1'b0);
      chk1("mr_pc_wr", O_pc_write, 1'b0);
      chk16("mr_instr", O_instr, 16'h0000);
      chk16("mr_addr", O_mem_addr, 16'h0000);
      tick();
      I_mem_ack = 1'b0;
      chk1("mr_restart_req", O_mem_req, 1'b1);
      chk16("mr_restart_addr", O_mem_addr, 16'h0000);
      chk1("mr_late_ack_ign", O_instr_valid, 1'b0);

      // Randomized traffic against the fetch-stream model
      last_addr = 16'hFFFE;
      exp_addr  = 16'h0000;
      br_tgt    = 16'h0000;
      exp_instr = 16'h0000;
      br_pend   = 1'b0;
      exp_valid = 1'b0;
      busy      = 1'b0;
      prev_req  = 1'b0;
      lat       = 0;
      age       = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (O_mem_req && !prev_req) begin
            exp_addr  = br_pend ? (br_tgt & 16'hFFFE) : last_addr + 16'd2;
            br_pend   = 1'b0;
            last_addr = exp_addr;
         end
         if (O_mem_req)
            chk16("rnd_addr", O_mem_addr, exp_addr);
         chk1("rnd_valid", O_instr_valid, exp_valid);
         if (exp_valid) begin
            chk16("rnd_instr", O_instr, exp_instr);
            chk1("rnd_no_req_hold", O_mem_req, 1'b0);
         end
         chk1("rnd_no_err", O_fetch_err, 1'b0);
         prev_req = O_mem_req;

         br  = ($urandom % 8) == 0;
         tgt = 16'($urandom) & 16'h0FFE;
         rdy = ($urandom % 2) == 0;
         ack = 1'b0;
         if (O_mem_req && !busy) begin
            busy = 1'b1;
            lat  = int'($urandom % 4);
         end
         if (busy) begin
            if (lat == 0) begin
               ack  = 1'b1;
               busy = 1'b0;
            end else begin
               lat--;
            end
         end
         I_branch        = br;
         I_branch_target = tgt;
         I_instr_ready   = rdy;
         I_mem_ack       = ack;
         I_mem_data      = ack ? memf(last_addr) : 16'($urandom);

         if (br) begin
            br_pend = 1'b1;
            br_tgt  = tgt;
         end
         if (ack && !br_pend) begin
            exp_valid = 1'b1;
            exp_instr = memf(last_addr);
            age       = 0;
         end else if (br) begin
            exp_valid = 1'b0;
         end else if (exp_valid && rdy && age >= 1) begin
            exp_valid = 1'b0;
         end else if (exp_valid) begin
            age++;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
